// File: rtl/proc_control_fsm_pkg.sv
// Shared definitions for the simple-processor control unit: opcodes,
// FSM state encoding and shared-bus source select codes.
package proc_ctrl_pkg;

    // Control step of the current instruction
    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } state_t;

    // Opcode field IR[15:13]
    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    // Shared-bus source codes beyond the register file
    localparam logic [3:0] SEL_PC  = 4'd7;
    localparam logic [3:0] SEL_G   = 4'd8;
    localparam logic [3:0] SEL_DIN = 4'd9;

    // Bus select code for a general register R0..R7
    function automatic logic [3:0] reg_sel(input logic [2:0] r);
        return {1'b0, r};
    endfunction

endpackage

// File: rtl/proc_control_fsm_if.sv
// Control-unit <-> datapath signal bundle. The control FSM uses the
// master modport; the datapath (or a testbench) uses the slave modport.
interface proc_control_fsm_if #(
    parameter int IW   = 16,
    parameter int NREG = 8
);
    logic            Run;
    logic [IW-1:0]   IR;
    logic            Gnz;
    logic            IRin;
    logic [NREG-1:0] Rin;
    logic            Ain;
    logic            Gin;
    logic            AddSub;
    logic [3:0]      BusSel;
    logic            ADDRin;
    logic            DOUTin;
    logic            W_D;
    logic            IncrPc;
    logic            Done;

    modport master (
        input  Run, IR, Gnz,
        output IRin, Rin, Ain, Gin, AddSub, BusSel,
               ADDRin, DOUTin, W_D, IncrPc, Done
    );

    modport slave (
        output Run, IR, Gnz,
        input  IRin, Rin, Ain, Gin, AddSub, BusSel,
               ADDRin, DOUTin, W_D, IncrPc, Done
    );
endinterface

// File: rtl/proc_control_fsm_reg_sel_dec.sv
// 3-to-NREG one-hot decoder turning a register field into load enables.
module reg_sel_dec #(
    parameter int NREG = 8
) (
    input  logic [2:0]      sel,
    input  logic            en,
    output logic [NREG-1:0] onehot
);
    // Assert exactly one enable bit when enabled and the index exists
    always_comb begin
        onehot = '0;
        if (en && (int'(sel) < NREG)) begin
            onehot[sel] = 1'b1;
        end
    end
endmodule

// File: rtl/proc_control_fsm.sv
// Multi-cycle control FSM for the 16-bit simple processor.
// Fetches (T0-T2) then sequences datapath enables per opcode (T3-T5).
// Optional feature: define CTRL_MVNZ_EN to make opcode 110 a
// conditional move on Gnz; otherwise 110 behaves as a NOP.
module proc_control_fsm
    import proc_ctrl_pkg::*;
#(
    parameter int IW   = 16,
    parameter int NREG = 8
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    proc_control_fsm_if.master   ctrl
);

    state_t     state;
    state_t     state_next;

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;

    logic       irin;
    logic       rin_en;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic [3:0] bussel;
    logic       addrin;
    logic       doutin;
    logic       w_d;
    logic       incr_pc;
    logic       done;

    logic [NREG-1:0] rin_onehot;

    assign opcode = ctrl.IR[IW-1  -: 3];
    assign rx     = ctrl.IR[IW-4  -: 3];
    assign ry     = ctrl.IR[IW-7  -: 3];

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: fetch is fixed, execute length depends on opcode
    always_comb begin
        state_next = T0;
        case (state)
            T0: state_next = ctrl.Run ? T1 : T0;
            T1: state_next = T2;
            T2: state_next = T3;
            T3: begin
                case (opcode)
                    OP_MVI, OP_ADD, OP_SUB, OP_LD, OP_ST: state_next = T4;
                    default:                              state_next = T0;
                endcase
            end
            T4: state_next = (opcode == OP_ST) ? T0 : T5;
            T5: state_next = T0;
            default: state_next = T0;
        endcase
    end

    // Output decode from state and IR; everything held low during reset
    always_comb begin
        irin    = 1'b0;
        rin_en  = 1'b0;
        ain     = 1'b0;
        gin     = 1'b0;
        addsub  = 1'b0;
        bussel  = 4'd0;
        addrin  = 1'b0;
        doutin  = 1'b0;
        w_d     = 1'b0;
        incr_pc = 1'b0;
        done    = 1'b0;
        if (Resetn) begin
            case (state)
                T0: begin
                    if (ctrl.Run) begin
                        bussel  = SEL_PC;
                        addrin  = 1'b1;
                        incr_pc = 1'b1;
                    end
                end
                T1: begin
                    // memory wait state
                end
                T2: irin = 1'b1;
                T3: begin
                    case (opcode)
                        OP_MV: begin
                            bussel = reg_sel(ry);
                            rin_en = 1'b1;
                            done   = 1'b1;
                        end
                        OP_MVI: begin
                            bussel  = SEL_PC;
                            addrin  = 1'b1;
                            incr_pc = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            bussel = reg_sel(rx);
                            ain    = 1'b1;
                        end
                        OP_LD, OP_ST: begin
                            bussel = reg_sel(ry);
                            addrin = 1'b1;
                        end
`ifdef CTRL_MVNZ_EN
                        OP_MVNZ: begin
                            done = 1'b1;
                            if (ctrl.Gnz) begin
                                bussel = reg_sel(ry);
                                rin_en = 1'b1;
                            end
                        end
`endif
                        default: done = 1'b1;
                    endcase
                end
                T4: begin
                    case (opcode)
                        OP_ADD, OP_SUB: begin
                            bussel = reg_sel(ry);
                            gin    = 1'b1;
                            addsub = opcode[0];
                        end
                        OP_ST: begin
                            bussel = reg_sel(rx);
                            doutin = 1'b1;
                            w_d    = 1'b1;
                            done   = 1'b1;
                        end
                        default: begin
                            // mvi/ld wait for memory
                        end
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_ADD, OP_SUB: begin
                            bussel = SEL_G;
                            rin_en = 1'b1;
                            done   = 1'b1;
                        end
                        OP_MVI, OP_LD: begin
                            bussel = SEL_DIN;
                            rin_en = 1'b1;
                            done   = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    reg_sel_dec #(
        .NREG (NREG)
    ) u_reg_sel_dec (
        .sel    (rx),
        .en     (rin_en),
        .onehot (rin_onehot)
    );

    assign ctrl.IRin   = irin;
    assign ctrl.Rin    = rin_onehot;
    assign ctrl.Ain    = ain;
    assign ctrl.Gin    = gin;
    assign ctrl.AddSub = addsub;
    assign ctrl.BusSel = bussel;
    assign ctrl.ADDRin = addrin;
    assign ctrl.DOUTin = doutin;
    assign ctrl.W_D    = w_d;
    assign ctrl.IncrPc = incr_pc;
    assign ctrl.Done   = done;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Testbench for proc_control_fsm: table vectors, random instruction
// stream against a per-instruction reference model, reset corner cases.
module tb_proc_control_fsm;

    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic       ain;
        logic       gin;
        logic       addsub;
        logic [3:0] bussel;
        logic       addrin;
        logic       doutin;
        logic       wd;
        logic       incrpc;
        logic       done;
    } outs_t;

    typedef struct {
        logic [15:0] ir;
        logic        gnz;
        int          lat;
        logic [7:0]  rin;
        logic [3:0]  bussel;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;
    outs_t exp_q[$];

    always #5 clk = ~clk;

    proc_control_fsm_if #(.IW(16), .NREG(8)) bus ();

    proc_control_fsm #(.IW(16), .NREG(8)) dut (
        .Clock  (clk),
        .Resetn (resetn),
        .ctrl   (bus.master)
    );

    function automatic outs_t cur();
        outs_t o;
        o.irin   = bus.IRin;
        o.rin    = bus.Rin;
        o.ain    = bus.Ain;
        o.gin    = bus.Gin;
        o.addsub = bus.AddSub;
        o.bussel = bus.BusSel;
        o.addrin = bus.ADDRin;
        o.doutin = bus.DOUTin;
        o.wd     = bus.W_D;
        o.incrpc = bus.IncrPc;
        o.done   = bus.Done;
        return o;
    endfunction

    function automatic outs_t fetch_word();
        outs_t o = '0;
        o.bussel = 4'd7;
        o.addrin = 1'b1;
        o.incrpc = 1'b1;
        return o;
    endfunction

    // Reference: list of expected output words per cycle, T0 onward
    function automatic void build_model(input logic [15:0] ir, input logic gnz);
        logic [2:0] op;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [7:0] wr;
        outs_t o;
        op = ir[15:13];
        rx = ir[12:10];
        ry = ir[9:7];
        wr = 8'(1 << rx);
        exp_q.delete();
        exp_q.push_back(fetch_word());
        o = '0; exp_q.push_back(o);
        o = '0; o.irin = 1'b1; exp_q.push_back(o);
        case (op)
            3'd0: begin
                o = '0; o.bussel = {1'b0, ry}; o.rin = wr; o.done = 1'b1; exp_q.push_back(o);
            end
            3'd1: begin
                exp_q.push_back(fetch_word());
                o = '0; exp_q.push_back(o);
                o = '0; o.bussel = 4'd9; o.rin = wr; o.done = 1'b1; exp_q.push_back(o);
            end
            3'd2, 3'd3: begin
                o = '0; o.bussel = {1'b0, rx}; o.ain = 1'b1; exp_q.push_back(o);
                o = '0; o.bussel = {1'b0, ry}; o.gin = 1'b1; o.addsub = op[0]; exp_q.push_back(o);
                o = '0; o.bussel = 4'd8; o.rin = wr; o.done = 1'b1; exp_q.push_back(o);
            end
            3'd4: begin
                o = '0; o.bussel = {1'b0, ry}; o.addrin = 1'b1; exp_q.push_back(o);
                o = '0; exp_q.push_back(o);
                o = '0; o.bussel = 4'd9; o.rin = wr; o.done = 1'b1; exp_q.push_back(o);
            end
            3'd5: begin
                o = '0; o.bussel = {1'b0, ry}; o.addrin = 1'b1; exp_q.push_back(o);
                o = '0; o.bussel = {1'b0, rx}; o.doutin = 1'b1; o.wd = 1'b1; o.done = 1'b1; exp_q.push_back(o);
            end
            3'd6: begin
                o = '0; o.done = 1'b1;
`ifdef CTRL_MVNZ_EN
                if (gnz) begin
                    o.bussel = {1'b0, ry};
                    o.rin    = wr;
                end
`endif
                exp_q.push_back(o);
            end
            default: begin
                o = '0; o.done = 1'b1; exp_q.push_back(o);
            end
        endcase
        if (gnz === 1'bx) exp_q.delete();
    endfunction

    task automatic chk_o(input string nm, input outs_t a, input outs_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, a, e);
        end
    endtask

    task automatic chk_i(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, a, e);
        end
    endtask

    task automatic chk_inv(input string nm, input outs_t a);
        checks++;
        if (a.incrpc && a.rin[7]) begin
            failures++;
            $display("FAIL %s IncrPc and Rin[7] together got=%h expected=0", nm, a.rin);
        end
    endtask

    // Run one instruction from T0 (called at a falling edge); returns latency
    task automatic run_one(input string nm, input logic [15:0] ir, input logic gnz,
                           input bit hold_run, output int lat, output outs_t at_done);
        outs_t a;
        build_model(ir, gnz);
        bus.IR  = ir;
        bus.Gnz = gnz;
        bus.Run = 1'b1;
        lat     = 0;
        at_done = '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            a = cur();
            if (i < exp_q.size()) chk_o($sformatf("%s step%0d", nm, i), a, exp_q[i]);
            else                  chk_o($sformatf("%s overrun%0d", nm, i), a, '0);
            chk_inv($sformatf("%s step%0d", nm, i), a);
            @(posedge clk);
            @(negedge clk);
            if (!hold_run) bus.Run = 1'b0;
            if (a.done) begin
                lat     = i + 1;
                at_done = a;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout got=no_done expected=done", nm);
        end
    endtask

    vec_t  tbl[12];
    int    lat;
    outs_t dn;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // mv R3,R6
        tbl[0]  = '{16'h0F00, 1'b0, 4, 8'h08, 4'd6};
        // mvi R2
        tbl[1]  = '{16'h2800, 1'b0, 6, 8'h04, 4'd9};
        // add R5,R2
        tbl[2]  = '{16'h5500, 1'b0, 6, 8'h20, 4'd8};
        // sub R1,R3
        tbl[3]  = '{16'h6580, 1'b0, 6, 8'h02, 4'd8};
        // ld R0,R4
        tbl[4]  = '{16'h8200, 1'b1, 6, 8'h01, 4'd9};
        // st R4,R5
        tbl[5]  = '{16'hB280, 1'b0, 5, 8'h00, 4'd4};
`ifdef CTRL_MVNZ_EN
        tbl[6]  = '{16'hDC00, 1'b1, 4, 8'h80, 4'd0};
`else
        tbl[6]  = '{16'hDC00, 1'b1, 4, 8'h00, 4'd0};
`endif
        tbl[7]  = '{16'hDC00, 1'b0, 4, 8'h00, 4'd0};
        // reserved
        tbl[8]  = '{16'hE900, 1'b1, 4, 8'h00, 4'd0};
        // mv R7,R7 (jump)
        tbl[9]  = '{16'h1F80, 1'b0, 4, 8'h80, 4'd7};
        // ld R7,R7 (jump)
        tbl[10] = '{16'h9F80, 1'b0, 6, 8'h80, 4'd9};
        // mvi R1 (0x2400 encodes Rx=1)
        tbl[11] = '{16'h2400, 1'b0, 6, 8'h02, 4'd9};

        // Reset held with Run=1: everything low
        resetn  = 1'b0;
        bus.Run = 1'b1;
        bus.IR  = 16'h0000;
        bus.Gnz = 1'b0;
        @(negedge clk); #1;
        chk_o("reset_hold0", cur(), '0);
        @(negedge clk); #1;
        chk_o("reset_hold1", cur(), '0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk_o("first_fetch", cur(), fetch_word());
        bus.Run = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        chk_o("idle_t0", cur(), '0);
        @(negedge clk);

        // Table vectors, back to back with Run held
        for (int v = 0; v < 12; v++) begin
            run_one($sformatf("vec%0d", v), tbl[v].ir, tbl[v].gnz, 1'b1, lat, dn);
            chk_i($sformatf("vec%0d latency", v), lat, tbl[v].lat);
            chk_i($sformatf("vec%0d rin_at_done", v), int'(dn.rin), int'(tbl[v].rin));
            chk_i($sformatf("vec%0d bussel_at_done", v), int'(dn.bussel), int'(tbl[v].bussel));
        end

        // Random instruction stream against the model
        for (int n = 0; n < 40; n++) begin
            run_one($sformatf("rnd%0d", n), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, lat, dn);
        end

        // Run dropped mid-instruction: add completes, then FSM idles in T0
        run_one("rundrop", 16'h5500, 1'b0, 1'b0, lat, dn);
        chk_i("rundrop latency", lat, 6);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_o($sformatf("rundrop idle%0d", k), cur(), '0);
            @(posedge clk); @(negedge clk);
        end

        // Reset asserted in T4 of an add
        build_model(16'h5500, 1'b0);
        bus.IR  = 16'h5500;
        bus.Gnz = 1'b0;
        bus.Run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_o($sformatf("abort step%0d", i), cur(), exp_q[i]);
            @(posedge clk); @(negedge clk);
        end
        #1;
        chk_o("abort T4", cur(), exp_q[4]);
        #1;
        resetn = 1'b0;
        #1;
        chk_o("abort async_zero", cur(), '0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); @(negedge clk); #1;
            chk_o($sformatf("abort no_done%0d", k), cur(), '0);
        end
        bus.Run = 1'b0;
        resetn  = 1'b1;
        #1;
        chk_o("abort released_t0", cur(), '0);
        @(posedge clk); @(negedge clk); #1;
        chk_o("abort still_t0", cur(), '0);
        @(negedge clk);

        // Resumes normally afterwards
        run_one("resume", 16'h0F00, 1'b0, 1'b0, lat, dn);
        chk_i("resume latency", lat, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
